// File: rtl/serial_subtractor_8bit_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8bit_if
//
// Bundles the request and result signals of the bit-serial subtractor.
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// ready=1. x, y and bin are captured on that edge only. start is ignored
// whenever ready=0. done pulses for one cycle when diff/bout/ovf/zero have
// just been updated; those results then hold until the next completion.
//
// Signals:
//   start  requester -> subtractor   request (sampled only while ready=1)
//   x      requester -> subtractor   minuend
//   y      requester -> subtractor   subtrahend
//   bin    requester -> subtractor   borrow in
//   ready  subtractor -> requester   idle, able to accept start
//   busy   subtractor -> requester   slices in progress
//   done   subtractor -> requester   one-cycle completion pulse
//   diff   subtractor -> requester   x - y - bin modulo 2^WIDTH
//   bout   subtractor -> requester   unsigned borrow out
//   ovf    subtractor -> requester   signed overflow
//   zero   subtractor -> requester   diff == 0
// -----------------------------------------------------------------------------
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, x, y, bin,
        input  ready, busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, x, y, bin,
        output ready, busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_8bit
//
// Bit-serial two's-complement subtractor: diff = x - y - bin, one bit slice per
// clock through a single full-adder slice fed with the inverted subtrahend.
// The initial carry is ~bin, so the slice chain evaluates x + ~y + 1 - bin.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        request/result bundle (slave side), see serial_subtractor_8bit_if
//   dbg_state  current FSM state for observation: 0 IDLE, 1 RUN, 2 DONE
//
// Timing: start accepted at edge E0; slices run on E1..E(WIDTH); results and
// the done pulse appear after E(WIDTH); ready returns at E(WIDTH+1).
// -----------------------------------------------------------------------------
module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_subtractor_8bit_if.slave  bus,
    output logic [1:0]               dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             xsign_q, xsign_d;
    logic             ysign_q, ysign_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-adder slice on the current LSBs, with the subtrahend bit inverted.
    logic             slice_a;
    logic             slice_b;
    logic             slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        slice_a   = xs_q[0];
        slice_b   = ~ys_q[0];
        slice_s   = slice_a ^ slice_b ^ c_q;
        slice_c   = (slice_a & slice_b) | (slice_a & c_q) | (slice_b & c_q);
        res_shift = {slice_s, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        xsign_d = xsign_q;
        ysign_d = ysign_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    xs_d    = bus.x;
                    ys_d    = bus.y;
                    c_d     = ~bus.bin;
                    cnt_d   = '0;
                    xsign_d = bus.x[WIDTH-1];
                    ysign_d = bus.y[WIDTH-1];
                    state_d = S_RUN;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                res_d = res_shift;
                c_d   = slice_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last slice: commit all four results together so they
                    // are never observed in a mixed old/new state.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_shift;
                    bout_d  = ~slice_c;
                    ovf_d   = (xsign_q ^ ysign_q) & (res_shift[WIDTH-1] ^ xsign_q);
                    zero_d  = (res_shift == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            xsign_q <= 1'b0;
            ysign_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            xsign_q <= xsign_d;
            ysign_q <= ysign_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
module tb_serial_subtractor_8bit;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_8bit_if #(.WIDTH(W)) ifc ();
    logic [1:0] dbg_state;

    serial_subtractor_8bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    // entry = {ovf, bout, zero, diff}
    logic [W+2:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_seen = 0;
    int n_pushed  = 0;
    int last_done_cyc = -1;
    bit check_gap = 1'b0;
    logic [W-1:0] last_diff = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
        int ux, uy, sx, sy, d, sd, m;
        logic [W-1:0] r;
        logic bo, ov, z;
        m  = 1 << W;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        d  = ux - uy - int'(b);
        sd = sx - sy - int'(b);
        bo = (d < 0);
        ov = (sd < -(m / 2)) || (sd > (m / 2) - 1);
        r  = W'((d + 2 * m) % m);
        z  = (r == 0);
        return {ov, bo, z, r};
    endfunction

    always @(posedge clk) cyc++;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W+2:0] e;
        check("onehot_ready_busy_done", 32'($countones({ifc.ready, ifc.busy, ifc.done})), 32'd1);
        if (!rst && ifc.done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("diff", 32'(ifc.diff), 32'(e[W-1:0]));
                check("zero", 32'(ifc.zero), 32'(e[W]));
                check("bout", 32'(ifc.bout), 32'(e[W+1]));
                check("ovf",  32'(ifc.ovf),  32'(e[W+2]));
                last_diff = e[W-1:0];
            end
            if (check_gap && last_done_cyc >= 0)
                check("done_period", 32'(cyc - last_done_cyc), 32'(W + 2));
            last_done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    // One call = one cycle. Inputs change at the falling edge; if the
    // subtractor is ready the following rising edge accepts them.
    task automatic drive(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
        @(negedge clk);
        ifc.start = s;
        ifc.x     = x;
        ifc.y     = y;
        ifc.bin   = b;
        if (s && ifc.ready && !rst) begin
            exp_q.push_back(model(x, y, b));
            n_pushed++;
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ifc.ready && k < 40) begin
            drive(1'b0, ifc.x, ifc.y, ifc.bin);
            k++;
        end
        if (!ifc.ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // One operation with cycle-exact timing checks. During the slices the
    // operand inputs are scrambled; with interfere set, a second start with
    // x=200 is raised at the third RUN cycle and must be ignored.
    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic b, input bit interfere);
        wait_ready();
        drive(1'b1, x, y, b);
        for (int k = 1; k <= W; k++) begin
            if (interfere && k == 3)
                drive(1'b1, 8'd200, W'($urandom), 1'($urandom));
            else
                drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
            check("busy_in_run", 32'(ifc.busy), 32'd1);
            check("diff_hold_in_run", 32'(ifc.diff), 32'(last_diff));
        end
        drive(1'b0, ifc.x, ifc.y, ifc.bin);
        check("done_latency", 32'(ifc.done), 32'd1);
        drive(1'b0, ifc.x, ifc.y, ifc.bin);
        check("done_single", 32'(ifc.done), 32'd0);
        check("ready_return", 32'(ifc.ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(ifc.ready), 32'd1);
        check({tag, "_busy"},  32'(ifc.busy),  32'd0);
        check({tag, "_done"},  32'(ifc.done),  32'd0);
        check({tag, "_diff"},  32'(ifc.diff),  32'd0);
        check({tag, "_bout"},  32'(ifc.bout),  32'd0);
        check({tag, "_ovf"},   32'(ifc.ovf),   32'd0);
        check({tag, "_zero"},  32'(ifc.zero),  32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int dones_before;
        logic [W-1:0] ax, ay, bx, by;
        logic ab, bb;

        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.x = '0;
        ifc.y = '0;
        ifc.bin = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Directed cases
        op(8'd9,    8'd1,  1'b0, 1'b0);
        op(8'd1,    8'd8,  1'b0, 1'b0);
        op(8'd8,    8'd8,  1'b1, 1'b0);
        op(8'h80,   8'h01, 1'b0, 1'b0);
        op(8'd5,    8'd5,  1'b0, 1'b0);
        op(8'd3,    8'd8,  1'b0, 1'b1);
        op(8'h00,   8'hFF, 1'b1, 1'b0);
        op(8'hFF,   8'h00, 1'b0, 1'b0);
        op(8'h7F,   8'hFF, 1'b0, 1'b0);

        // Reset during RUN: abort with no done pulse
        wait_ready();
        drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        repeat (4) drive(1'b0, ifc.x, ifc.y, ifc.bin);
        dones_before = done_seen;
        #1 rst = 1'b1;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        last_diff = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(1'b0, ifc.x, ifc.y, ifc.bin);
        check("abort_no_done", 32'(done_seen), 32'(dones_before));
        op(8'd2, 8'd8, 1'b1, 1'b0);

        // Randomized single operations with random idle gaps
        for (int i = 0; i < 16; i++) begin
            op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        end

        // start held high with two alternating operand sets
        ax = W'($urandom); ay = W'($urandom); ab = 1'($urandom);
        bx = W'($urandom); by = W'($urandom); bb = 1'($urandom);
        wait_ready();
        last_done_cyc = -1;
        check_gap = 1'b1;
        for (int i = 0; i < 6 * (W + 2); i++) begin
            if (i % 2 == 0) drive(1'b1, ax, ay, ab);
            else            drive(1'b1, bx, by, bb);
        end
        check_gap = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2 * (W + 2)) drive(1'b0, '0, '0, 1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("no_stuck_busy", 32'(ifc.ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
